// File: rtl/ov7670_pkg.sv
// Shared definitions for the OV7670 pixel-bus blocks.
//   - default timing constants (VGA, RGB565)
//   - FSM state encoding for the stream generator
//   - RGB444 -> RGB565 byte mapping; the capture path relies on this
//     exact bit placement to round-trip frames bit-exact
package ov7670_pkg;

  localparam int DEF_H_ACTIVE    = 640;
  localparam int DEF_V_ACTIVE    = 480;
  localparam int DEF_H_BLANK     = 144;
  localparam int DEF_VSYNC_LINES = 3;
  localparam int DEF_VBP_LINES   = 17;
  localparam int DEF_VFP_LINES   = 10;
  localparam int ADDR_W          = 19;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VSYNC  = 3'd1,
    ST_VBP    = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_VFP    = 3'd4
  } state_t;

  // px = {R4,G4,B4}. second=0 gives RRRRR GGG, second=1 gives GGG BBBBB,
  // with the missing LSBs filled by replicating the MSBs.
  function automatic logic [7:0] rgb565_byte(input logic [11:0] px, input logic second);
    logic [3:0] r4, g4, b4;
    r4 = px[11:8];
    g4 = px[7:4];
    b4 = px[3:0];
    if (!second) return {r4, r4[3], g4[3:1]};
    else         return {g4[0], g4[3:2], b4, b4[3]};
  endfunction

endpackage

// File: rtl/ov7670_timing_counter.sv
// Horizontal and per-state line counters for the stream generator.
// Ports:
//   pclk, reset   clock, async active-high reset
//   en            count enable (low holds both counters at 0)
//   last_line     index of the final line of the current state
//   h_nxt         value h_cnt takes at the next edge
//   line_nxt      value line_cnt takes at the next edge
//   eos           last cycle of the current state
// The "next" values are exported so the top can register its outputs
// one cycle ahead and still line up with the counters.
module ov7670_timing_counter
  import ov7670_pkg::*;
#(
  parameter int LINE_LEN = 1424,
  parameter int HW       = 11,
  parameter int LW       = 9
) (
  input  logic          pclk,
  input  logic          reset,
  input  logic          en,
  input  logic [LW-1:0] last_line,
  output logic [HW-1:0] h_nxt,
  output logic [LW-1:0] line_nxt,
  output logic          eos
);

  logic [HW-1:0] h_cnt;
  logic [LW-1:0] line_cnt;
  logic          eol;
  logic          line_last;

  assign eol       = (h_cnt == HW'(LINE_LEN - 1));
  assign line_last = (line_cnt == last_line);
  assign eos       = en & eol & line_last;

  always_comb begin
    h_nxt    = '0;
    line_nxt = '0;
    if (en) begin
      h_nxt    = eol ? '0 : h_cnt + 1'b1;
      line_nxt = eol ? (line_last ? '0 : line_cnt + 1'b1) : line_cnt;
    end
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      h_cnt    <= '0;
      line_cnt <= '0;
    end else begin
      h_cnt    <= h_nxt;
      line_cnt <= line_nxt;
    end
  end

endmodule

// File: rtl/ov7670_stream_gen.sv
// OV7670 pixel-bus transmitter: reads RGB444 pixels from a frame buffer and
// drives vsync/href/d as an OV7670 in RGB565 mode (two bytes per pixel).
// Ports:
//   pclk, reset   clock, async active-high reset
//   run           level; enables frame generation
//   rd_addr/rd_en frame-buffer read port, data returns one cycle later
//   rd_data       {R4,G4,B4}
//   vsync, href   frame / line sync, active-high
//   d             pixel byte, 0 outside href
//   busy          high in every state but IDLE
//   frame_done    one-cycle pulse on the last cycle of a frame
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_IDLE   | waiting for run, counters held at 0
// ST_VSYNC  | vsync high for VSYNC_LINES line periods
// ST_VBP    | vertical back porch
// ST_ACTIVE | V_ACTIVE lines of reads and href bursts
// ST_VFP    | vertical front porch, run resampled at the end
//
// Every output is registered from next-cycle values (state_d, h_nxt), so
// each output flop holds the value belonging to the current h_cnt.
module ov7670_stream_gen
  import ov7670_pkg::*;
#(
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int H_BLANK     = DEF_H_BLANK,
  parameter int VSYNC_LINES = DEF_VSYNC_LINES,
  parameter int VBP_LINES   = DEF_VBP_LINES,
  parameter int VFP_LINES   = DEF_VFP_LINES
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic        run,
  output logic [18:0] rd_addr,
  output logic        rd_en,
  input  logic [11:0] rd_data,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  d,
  output logic        busy,
  output logic        frame_done
);

  localparam int LINE_LEN  = 2 * H_ACTIVE + H_BLANK;
  localparam int HW        = $clog2(LINE_LEN);
  localparam int MAX_AB    = (VSYNC_LINES > VBP_LINES) ? VSYNC_LINES : VBP_LINES;
  localparam int MAX_CD    = (V_ACTIVE > VFP_LINES) ? V_ACTIVE : VFP_LINES;
  localparam int MAX_LINES = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int LW        = (MAX_LINES > 1) ? $clog2(MAX_LINES) : 1;

  localparam logic [HW-1:0] HREF_FIRST = HW'(2);
  localparam logic [HW-1:0] HREF_LAST  = HW'(2 * H_ACTIVE + 1);
  localparam logic [HW-1:0] RD_END     = HW'(2 * H_ACTIVE);
  localparam logic [HW-1:0] H_LAST     = HW'(LINE_LEN - 1);

  state_t        state, state_d;
  logic [LW-1:0] last_line;
  logic [HW-1:0] h_nxt;
  logic [LW-1:0] line_nxt;
  logic          eos;
  logic          href_d;
  logic [11:0]   pix_q;

  ov7670_timing_counter #(
    .LINE_LEN (LINE_LEN),
    .HW       (HW),
    .LW       (LW)
  ) u_timing (
    .pclk      (pclk),
    .reset     (reset),
    .en        (state != ST_IDLE),
    .last_line (last_line),
    .h_nxt     (h_nxt),
    .line_nxt  (line_nxt),
    .eos       (eos)
  );

  // Kept apart from the next-state logic so eos does not feed back into
  // the block that produces last_line.
  always_comb begin
    last_line = '0;
    case (state)
      ST_VSYNC:  last_line = LW'(VSYNC_LINES - 1);
      ST_VBP:    last_line = LW'(VBP_LINES - 1);
      ST_ACTIVE: last_line = LW'(V_ACTIVE - 1);
      ST_VFP:    last_line = LW'(VFP_LINES - 1);
      default:   last_line = '0;
    endcase
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:   if (run) state_d = ST_VSYNC;
      ST_VSYNC:  if (eos) state_d = ST_VBP;
      ST_VBP:    if (eos) state_d = ST_ACTIVE;
      ST_ACTIVE: if (eos) state_d = ST_VFP;
      ST_VFP:    if (eos) state_d = run ? ST_VSYNC : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign href_d = (state_d == ST_ACTIVE) && (h_nxt >= HREF_FIRST) && (h_nxt <= HREF_LAST);

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      rd_addr    <= '0;
      rd_en      <= 1'b0;
      vsync      <= 1'b0;
      href       <= 1'b0;
      d          <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      pix_q      <= '0;
    end else begin
      state      <= state_d;
      vsync      <= (state_d == ST_VSYNC);
      href       <= href_d;
      busy       <= (state_d != ST_IDLE);
      rd_en      <= (state_d == ST_ACTIVE) && (h_nxt < RD_END) && !h_nxt[0];
      frame_done <= (state_d == ST_VFP) && (h_nxt == H_LAST) &&
                    (line_nxt == LW'(VFP_LINES - 1));

      if (state_d == ST_VSYNC && state != ST_VSYNC) rd_addr <= '0;
      else if (rd_en)                                rd_addr <= rd_addr + 1'b1;

      // Even h_nxt: rd_data is valid now, emit the first byte and keep
      // the pixel for the second byte on the following cycle.
      if (href_d && !h_nxt[0]) begin
        d     <= rgb565_byte(rd_data, 1'b0);
        pix_q <= rd_data;
      end else if (href_d) begin
        d     <= rgb565_byte(pix_q, 1'b1);
      end else begin
        d     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ov7670_stream_gen.sv
module tb_ov7670_stream_gen;

  logic        pclk = 1'b0;
  logic        reset;
  logic        run;
  logic [18:0] rd_addr;
  logic        rd_en;
  logic [11:0] rd_data = '0;
  logic        vsync;
  logic        href;
  logic [7:0]  d;
  logic        busy;
  logic        frame_done;

  int n_checks = 0;
  int n_errors = 0;

  always #5 pclk = ~pclk;

  ov7670_stream_gen #(
    .H_ACTIVE    (4),
    .V_ACTIVE    (2),
    .H_BLANK     (6),
    .VSYNC_LINES (1),
    .VBP_LINES   (1),
    .VFP_LINES   (1)
  ) dut (
    .pclk       (pclk),
    .reset      (reset),
    .run        (run),
    .rd_addr    (rd_addr),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .vsync      (vsync),
    .href       (href),
    .d          (d),
    .busy       (busy),
    .frame_done (frame_done)
  );

  // Frame buffer contents and their hand-computed RGB565 byte pairs.
  logic [11:0] pix_tab [8] = '{12'hF00, 12'h0F0, 12'h00F, 12'hFFF,
                               12'h000, 12'h8A5, 12'h123, 12'h7C9};
  logic [7:0]  exp_bytes [16] = '{8'hF8, 8'h00, 8'h07, 8'hE0, 8'h00, 8'h1F, 8'hFF, 8'hFF,
                                  8'h00, 8'h00, 8'h8D, 8'h4A, 8'h11, 8'h06, 8'h76, 8'h73};

  always @(posedge pclk) if (rd_en) rd_data <= pix_tab[rd_addr[2:0]];

  int vs_cnt, vs_first, hr_cnt, hr_first, hr_bursts, both_cnt, d_stray;
  int rd_cnt, rd_first, first_addr, fd_cnt, fd_cycle, busy_low;
  int got_bytes [16];
  int got_addr [8];

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Samples 70 cycles (one small frame) at the falling edge; drops run
  // after sampling cycle drop_at when drop_at > 0.
  task automatic sample_frame(input int drop_at);
    logic prev_href;
    vs_cnt = 0; vs_first = -1; hr_cnt = 0; hr_first = -1; hr_bursts = 0;
    both_cnt = 0; d_stray = 0; rd_cnt = 0; rd_first = -1; first_addr = -1;
    fd_cnt = 0; fd_cycle = -1; busy_low = 0;
    for (int i = 0; i < 16; i++) got_bytes[i] = -1;
    for (int i = 0; i < 8; i++) got_addr[i] = -1;
    prev_href = 1'b0;
    for (int c = 1; c <= 70; c++) begin
      @(negedge pclk);
      if (c == 1) first_addr = int'(rd_addr);
      if (vsync) begin
        vs_cnt++;
        if (vs_first < 0) vs_first = c;
      end
      if (href) begin
        if (!prev_href) hr_bursts++;
        if (hr_first < 0) hr_first = c;
        if (hr_cnt < 16) got_bytes[hr_cnt] = int'(d);
        hr_cnt++;
      end else if (d != 8'h00) begin
        d_stray++;
      end
      if (vsync && href) both_cnt++;
      if (rd_en) begin
        if (rd_first < 0) rd_first = c;
        if (rd_cnt < 8) got_addr[rd_cnt] = int'(rd_addr);
        rd_cnt++;
      end
      if (frame_done) begin
        fd_cnt++;
        fd_cycle = c;
      end
      if (!busy) busy_low++;
      prev_href = href;
      if (c == drop_at) run = 1'b0;
    end
  endtask

  task automatic check_frame(input string tag);
    check_eq({tag, " vsync_first"}, vs_first, 1);
    check_eq({tag, " vsync_cycles"}, vs_cnt, 14);
    check_eq({tag, " href_first"}, hr_first, 31);
    check_eq({tag, " href_cycles"}, hr_cnt, 16);
    check_eq({tag, " href_bursts"}, hr_bursts, 2);
    check_eq({tag, " vsync_and_href"}, both_cnt, 0);
    check_eq({tag, " d_outside_href"}, d_stray, 0);
    check_eq({tag, " rd_first"}, rd_first, 29);
    check_eq({tag, " rd_count"}, rd_cnt, 8);
    check_eq({tag, " addr_at_vsync"}, first_addr, 0);
    check_eq({tag, " frame_done_count"}, fd_cnt, 1);
    check_eq({tag, " frame_done_cycle"}, fd_cycle, 70);
    check_eq({tag, " busy_low"}, busy_low, 0);
    for (int i = 0; i < 8; i++)
      check_eq($sformatf("%s rd_addr[%0d]", tag, i), got_addr[i], i);
    for (int i = 0; i < 16; i++)
      check_eq($sformatf("%s byte[%0d]", tag, i), got_bytes[i], int'(exp_bytes[i]));
  endtask

  initial begin
    int vs_after, busy_after, fd_after;
    reset = 1'b1;
    run   = 1'b0;
    repeat (3) @(negedge pclk);
    check_eq("reset_outputs", int'({vsync, href, d, rd_en, rd_addr, busy, frame_done}), 0);
    reset = 1'b0;
    repeat (5) @(negedge pclk);
    check_eq("idle_busy", int'(busy), 0);
    check_eq("idle_vsync", int'(vsync), 0);

    // Two back-to-back frames; run drops during the second frame's ACTIVE.
    run = 1'b1;
    sample_frame(0);
    check_frame("f1");
    sample_frame(35);
    check_frame("f2");

    vs_after = 0; busy_after = 0; fd_after = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge pclk);
      if (vsync) vs_after++;
      if (busy) busy_after++;
      if (frame_done) fd_after++;
    end
    check_eq("stopped_vsync", vs_after, 0);
    check_eq("stopped_busy", busy_after, 0);
    check_eq("stopped_frame_done", fd_after, 0);

    // Reset in the middle of an href burst, then a full frame after release.
    run = 1'b1;
    repeat (33) @(negedge pclk);
    check_eq("pre_reset_href", int'(href), 1);
    #2 reset = 1'b1;
    #1 check_eq("midframe_reset_outputs",
                int'({vsync, href, d, rd_en, rd_addr, busy, frame_done}), 0);
    @(negedge pclk);
    reset = 1'b0;
    sample_frame(0);
    check_frame("f3");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ov7670_stream_gen.md
# ov7670_stream_gen

Transmit-side model of the OV7670 pixel bus. It reads RGB444 pixels from a frame-buffer read port and drives `vsync`, `href` and `d[7:0]` as an OV7670 in RGB565 mode, two bytes per pixel. It sits opposite the capture block: it serves as a camera stand-in for loopback tests and as a source for downstream blocks that expect camera timing. A frame captured at full resolution and regenerated by this block round-trips bit-exact.

## Interface
Parameters:
- `H_ACTIVE`, 640, pixels per line.
- `V_ACTIVE`, 480, active lines per frame.
- `H_BLANK`, 144, pclk cycles of blanking per line; must be ≥ 2.
- `VSYNC_LINES`, 3, line periods with vsync high.
- `VBP_LINES`, 17, line periods between vsync fall and the first active line.
- `VFP_LINES`, 10, line periods after the last active line.

Ports:
- `pclk`  in  1  the only clock. All outputs are registered on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `run`  in  1  level; enables frame generation.
- `rd_addr`  out  19  frame-buffer read address.
- `rd_en`  out  1  read strobe.
- `rd_data`  in  12  RGB444 as {R4,G4,B4}, valid the cycle after `rd_en`.
- `vsync`  out  1  frame sync, active-high.
- `href`  out  1  line-valid, active-high.
- `d`  out  8  pixel byte.
- `busy`  out  1  high while a frame is in progress.
- `frame_done`  out  1  one-cycle pulse at the end of each frame.

## Operation
- Line period L = 2·H_ACTIVE + H_BLANK cycles. `h_cnt` counts 0..L-1 and wraps.
- FSM states: IDLE → VSYNC → VBP → ACTIVE → VFP.
  - IDLE: leaves when `run`=1, at `h_cnt`=0.
  - VSYNC: lasts VSYNC_LINES lines.
  - VBP: lasts VBP_LINES lines.
  - ACTIVE: lasts V_ACTIVE lines.
  - VFP: lasts VFP_LINES lines. At its last cycle, `frame_done` pulses, then the FSM goes to VSYNC if `run`=1, otherwise to IDLE.
- A `line_cnt` counts line periods within the current state and clears on each state change.
- `run` is sampled only in IDLE and at the end of VFP. Dropping `run` mid-frame finishes the frame.
- In VSYNC, `vsync`=1 for the whole line period. `rd_addr` is cleared to 0 on VSYNC entry.
- In an ACTIVE line:
  - At `h_cnt` = 2k (k = 0..H_ACTIVE-1), assert `rd_en` with `rd_addr` = current address.
  - `rd_addr` increments by 1 after each read, without wrapping inside a frame.
- Byte output, pixel k:
  - At `h_cnt` = 2k+2, `d` = {R4,R4[3],G4[3:1]}, i.e. RRRRR GGG of RGB565 with the LSBs replicated.
  - At `h_cnt` = 2k+3, `d` = {G4[0],G4[3:2],B4,B4[3]}.
  - Together these give G6 = {G4,G4[3:2]}, R5 = {R4,R4[3]} and B5 = {B4,B4[3]}.
- `href` = 1 exactly for `h_cnt` in [2, 2·H_ACTIVE+1] of ACTIVE lines, so each line has 2·H_ACTIVE href cycles.
- `d` = 0x00 whenever `href`=0.
- `vsync` and `href` are never high together.
- `busy` = 1 in every state except IDLE.

## Timing
- Reset values: all outputs 0, FSM in IDLE, counters 0. Reset asserted mid-frame clears everything immediately. After release, the block restarts from IDLE.
- Read latency is fixed at 1 cycle. The data byte appears on `d` 2 cycles after its `rd_en`.
- Frame length = (VSYNC_LINES + VBP_LINES + V_ACTIVE + VFP_LINES) · L cycles.
- First `vsync` rise comes 1 cycle after `run` is seen high in IDLE.
- Width rules:
  - `h_cnt` is sized by clog2(L).
  - `line_cnt` is sized by clog2 of the largest state length.
  - `rd_addr` is 19 bits; H_ACTIVE·V_ACTIVE must not exceed 2^19. Addresses are truncated to 19 bits.
- `frame_done` and the VFP→VSYNC transition happen in the same cycle, so back-to-back frames have no gap.

## Structure
- Shared package `ov7670_pkg` holds:
  - the default timing constants;
  - the FSM state encoding;
  - an RGB444→RGB565 byte function, shared with the capture path's bit mapping.
- Natural sub-module: `ov7670_timing_counter`. It owns `h_cnt`, `line_cnt` and the end-of-line/end-of-state strobes. The FSM, read-address logic and byte mux stay in the top.

## Test plan
Small parameters are used throughout unless stated: H_ACTIVE=4, V_ACTIVE=2, H_BLANK=6, VSYNC_LINES=1, VBP_LINES=1, VFP_LINES=1, giving L=14 and a 70-cycle frame.

- Reset, then `run`=1 held: required response is `vsync` high for 14 cycles and exactly 2 href bursts of 8 cycles each, then `frame_done` at cycle 70, with the next vsync starting immediately.
- RAM model returns `rd_data` = 12'hF00 at every address: required `d` sequence per pixel is 0xF8, 0x00. With 12'h0F0 it is 0x07, 0xE0. With 12'h00F it is 0x00, 0x1F.
- Address check: required `rd_addr` sequence is 0..7 with one `rd_en` per pixel, returning to 0 at the next VSYNC.
- `run` dropped during ACTIVE: the frame completes, `frame_done` pulses, the FSM enters IDLE, and `busy`=0 with no further vsync.
- Reset asserted mid-href: all outputs are 0 in the same cycle. After release with `run`=1, a full, correct frame follows.
- Loopback at default parameters: feed this block into the capture block at full resolution. The captured buffer must equal the source buffer bit-for-bit.
